alu_result_log: RTL
===================

// Module: alu_result_log
// PURPOSE
//  - Parametrised successor to the ALU + result-memory top level: registered W-bit ALU with valid/ready
//    input, logging every result into an internal DEPTH-entry circular buffer with a registered read port.
//  - Adds flow control, fill tracking and a multi-cycle memory clear sequence.
//  - Sits between the operand source and the debug/readback logic.
// PARAMETERS
//  - W      8   operand width; results are W+1 bits (carry/borrow/shift-out in bit W)
//  - DEPTH  16  log entries; power of two, >=2; AW = $clog2(DEPTH)
// PORTS
//  - clk       in   1     sole clock, rising edge
//  - rst       in   1     synchronous, active-high reset
//  - in_valid  in   1     operand/op presented
//  - in_ready  out  1     block accepts; transfer when in_valid && in_ready
//  - a, b      in   W     operands
//  - sel       in   3     opcode
//  - clr       in   1     one-cycle request to zero the log
//  - res_valid out  1     res holds a new result this cycle (1-cycle pulse per op)
//  - res       out  W+1   last registered result
//  - rd_addr   in   AW    log read address
//  - rd_data   out  W+1   mem[rd_addr], 1-cycle latency
//  - wr_ptr    out  AW    next log slot to be written
//  - count     out  AW+1  valid entries, 0..DEPTH
//  - full      out  1     count == DEPTH
//  - busy      out  1     clear sequence in progress
// BEHAVIOUR
//  - Ops: 000 a+b | 001 a-b (W+1-bit two's complement, bit W = borrow) | 010 a&b | 011 a|b | 100 a^b
//    | 101 ~a | 110 a<<1 (bit W = a[W-1]) | 111 a>>1; logic ops and >> zero-extend bit W.
//  - Latency: transfer at edge t -> res/res_valid at t+1; mem[wr_ptr] written at edge t+1 from res;
//    wr_ptr increments mod DEPTH (wraps DEPTH-1 -> 0); count +1, saturating at DEPTH.
//  - Back-to-back transfers every cycle are supported; one write per result, none dropped.
//  - Read port is read-first: same-cycle write to rd_addr returns old data; rd_data updates every cycle.
//  - FSM: RUN (normal) / CLEAR.
//    RUN --clr--> CLEAR; an in-flight result is still written at the clr edge, then the sweep starts.
//    CLEAR writes 0 to addr 0..DEPTH-1, one per cycle, DEPTH cycles; busy=1, in_ready=0.
//    Last write -> RUN with wr_ptr=0, count=0. clr while in CLEAR is ignored.
//  - clr and a transfer in the same cycle: the transfer is not accepted (in_ready already deasserted
//    combinationally by clr).
//  - Reset (any time, incl. mid-CLEAR): state=RUN, res=0, res_valid=0, wr_ptr=0, count=0, busy=0,
//    rd_data=0; memory contents undefined. An in-flight result is discarded.
// CONFIGURATION
//  - ALU_LOG_WRAP_EN defined: log overwrites the oldest entry when full; count stays at DEPTH;
//    in_ready = (state==RUN) && !clr.
//  - Not defined: no overwrite; in_ready = (state==RUN) && !clr && (count + res_valid < DEPTH),
//    so an in-flight result is counted before the buffer fills; full stalls input until clr.
// STRUCTURE
//  - Package alu_log_pkg: opcode enum (OP_ADD..OP_SHR, 3 bits), state enum {ST_RUN, ST_CLEAR}.
//  - Sub-module alu_core: purely combinational W-bit ALU (a, b, sel -> W+1 result), instanced once.
//  - Top holds the result register, pointer/count logic, FSM and the inferred RAM (single write port,
//    registered read port).
// TESTING (W=8, DEPTH=16)
//  - a=200,b=100,sel=000 accepted at edge t -> res=9'h12C, res_valid at t+1;
//    rd_addr=0 two cycles later -> rd_data=9'h12C.
//  - a=5,b=7,sel=001 -> res=9'h1FE; sel=110 with a=8'h81 -> 9'h102; sel=101 with a=8'h0F -> 9'h0F0.
//  - 16 back-to-back ops without macro -> count=16, full=1, in_ready=0, 17th held;
//    with ALU_LOG_WRAP_EN the 17th overwrites addr 0, wr_ptr=1, count=16.
//  - Fill 5 entries, pulse clr -> busy high exactly 16 cycles, all addrs read 0, then count=0, wr_ptr=0.
//  - Assert rst at cycle 4 of CLEAR -> next cycle busy=0, in_ready=1, count=0, res_valid=0.
//  - Read and write to addr 3 in the same cycle -> rd_data returns the previous contents.

Source files
------------

// File: rtl/alu_log_pkg.sv
// Shared types for the ALU result log: opcodes and FSM states.
// Feature macro: ALU_LOG_WRAP_EN (see alu_result_log.sv).
package alu_log_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_XOR = 3'b100,
    OP_NOT = 3'b101,
    OP_SHL = 3'b110,
    OP_SHR = 3'b111
  } op_e;

  typedef enum logic {
    ST_RUN   = 1'b0,
    ST_CLEAR = 1'b1
  } state_e;

endpackage

// File: rtl/alu_result_log_alu_core.sv
// Combinational W-bit ALU; bit W carries carry/borrow/shift-out.
// Logic ops and right shift zero-extend bit W.
module alu_core
  import alu_log_pkg::*;
#(
  parameter int W = 8
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic [2:0]   sel,
  output logic [W:0]   result
);

  // opcode decode
  always_comb begin
    result = '0;
    unique case (op_e'(sel))
      OP_ADD: result = {1'b0, a} + {1'b0, b};
      OP_SUB: result = {1'b0, a} - {1'b0, b};
      OP_AND: result = {1'b0, a & b};
      OP_OR:  result = {1'b0, a | b};
      OP_XOR: result = {1'b0, a ^ b};
      OP_NOT: result = {1'b0, ~a};
      OP_SHL: result = {a, 1'b0};
      OP_SHR: result = {2'b00, a[W-1:1]};
    endcase
  end

endmodule

// File: rtl/alu_result_log.sv
// Registered ALU with valid/ready input logging results to a circular RAM.
// ALU_LOG_WRAP_EN: overwrite oldest entry when full instead of stalling.
module alu_result_log
  import alu_log_pkg::*;
#(
  parameter int W     = 8,
  parameter int DEPTH = 16,
  localparam int AW   = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic [W-1:0]  a,
  input  logic [W-1:0]  b,
  input  logic [2:0]    sel,
  input  logic          clr,
  output logic          res_valid,
  output logic [W:0]    res,
  input  logic [AW-1:0] rd_addr,
  output logic [W:0]    rd_data,
  output logic [AW-1:0] wr_ptr,
  output logic [AW:0]   count,
  output logic          full,
  output logic          busy
);

  state_e        state;
  logic [AW-1:0] clr_addr;
  logic [W:0]    alu_y;
  logic [W:0]    mem [DEPTH];
  logic          accept;
  logic          log_wr;
  logic          we;
  logic [AW-1:0] waddr;
  logic [W:0]    wdata;
  logic [AW+1:0] pending;

  alu_core #(.W(W)) u_alu (
    .a      (a),
    .b      (b),
    .sel    (sel),
    .result (alu_y)
  );

  assign pending = {1'b0, count} + (AW+2)'(res_valid);

`ifdef ALU_LOG_WRAP_EN
  assign in_ready = (state == ST_RUN) && !clr;
`else
  assign in_ready = (state == ST_RUN) && !clr
                 && (pending < (AW+2)'(DEPTH));
`endif

  assign accept = in_valid && in_ready;
  assign log_wr = (state == ST_RUN) && res_valid;
  assign busy   = (state == ST_CLEAR);
  assign full   = (count == (AW+1)'(DEPTH));

  assign we    = log_wr || busy;
  assign waddr = busy ? clr_addr : wr_ptr;
  assign wdata = busy ? '0 : res;

  // result register: one res_valid pulse per accepted op
  always_ff @(posedge clk) begin
    if (rst) begin
      res       <= '0;
      res_valid <= 1'b0;
    end else begin
      res_valid <= accept;
      if (accept) res <= alu_y;
    end
  end

  // FSM, write pointer and fill count
  always_ff @(posedge clk) begin
    if (rst) begin
      state    <= ST_RUN;
      clr_addr <= '0;
      wr_ptr   <= '0;
      count    <= '0;
    end else begin
      if (log_wr) begin
        wr_ptr <= wr_ptr + 1'b1;
        if (!full) count <= count + 1'b1;
      end
      unique case (state)
        ST_RUN: begin
          if (clr) begin
            state    <= ST_CLEAR;
            clr_addr <= '0;
          end
        end
        ST_CLEAR: begin
          clr_addr <= clr_addr + 1'b1;
          if (clr_addr == AW'(DEPTH - 1)) begin
            state  <= ST_RUN;
            wr_ptr <= '0;
            count  <= '0;
          end
        end
      endcase
    end
  end

  // log RAM write port (results or clear sweep)
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  // registered read-first read port
  always_ff @(posedge clk) begin
    if (rst) rd_data <= '0;
    else     rd_data <= mem[rd_addr];
  end

endmodule
